furv_de_queued: RTL and testbench

//  Queued decode stage for RV32I. Successor to the single-slot decode: adds a parametrised instruction queue,

---
 rtl/furv_de_queued_if.sv | 39 +++
 rtl/furv_de_queued.sv | 259 +++++++++++++++++++++++++
 tb/tb_furv_de_queued.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/furv_de_queued_if.sv
// Handshake and data bundle around the queued decode stage.
// The environment (fetch, register file, writeback, execute) is the master; the decode stage is the slave.
interface furv_de_queued_if;
  logic        fe_valid;
  logic        fe_ready;
  logic [31:0] fe_instruction;
  logic [31:0] fe_pc;
  logic [4:0]  rf_rs1_index;
  logic [4:0]  rf_rs2_index;
  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        de_valid;
  logic        de_ready;
  logic [31:0] de_pc;
  logic [31:0] de_alu_a;
  logic [31:0] de_alu_b;
  logic [31:0] de_alu_rs1;
  logic [31:0] de_alu_rs2;
  logic [4:0]  de_rd;
  logic [15:0] de_ctrl;

  modport master (
    output fe_valid, fe_instruction, fe_pc, rf_rs1, rf_rs2,
           wb_valid, wb_rd, wb_data, flush, de_ready,
    input  fe_ready, rf_rs1_index, rf_rs2_index,
           de_valid, de_pc, de_alu_a, de_alu_b, de_alu_rs1, de_alu_rs2, de_rd, de_ctrl
  );

  modport slave (
    input  fe_valid, fe_instruction, fe_pc, rf_rs1, rf_rs2,
           wb_valid, wb_rd, wb_data, flush, de_ready,
    output fe_ready, rf_rs1_index, rf_rs2_index,
           de_valid, de_pc, de_alu_a, de_alu_b, de_alu_rs1, de_alu_rs2, de_rd, de_ctrl
  );
endinterface

// File: rtl/furv_de_queued.sv
// RV32I decode stage: instruction queue, register scoreboard with writeback bypass,
// illegal-opcode flagging and flush, feeding a single registered output slot.
module furv_de_queued #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             rst,
  furv_de_queued_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;

  typedef struct packed {
    logic       alu_sel_logic;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       branch;
    logic       mem;
    logic       mem_write;
    logic [1:0] mem_width;
    logic       mem_unsigned;
    logic       reverse_wb;
    logic       lt;
    logic       invert_cmp;
    logic       unsigned_cmp;
    logic       illegal;
  } ctrl_t;

  // Instruction queue
  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, issue;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = bus.fe_valid && !full && !bus.flush;
  assign bus.fe_ready = !full;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: queue storage has no reset; the pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr[AW-1:0]] <= bus.fe_instruction;
      q_pc[wr_ptr[AW-1:0]]    <= bus.fe_pc;
    end
  end

  // Head operands and scoreboard lookup
  logic [31:0]      head_instr, head_pc, rs1_val, rs2_val, rs1_rev;
  logic [4:0]       rs1_idx, rs2_idx, opc;
  logic [2:0]       f3;
  logic [CNT_W-1:0] sb_cnt [32];
  logic [CNT_W-1:0] sb_next [32];
  logic             byp1, byp2, rdy1, rdy2, need1, need2, hazard;

  assign head_instr = q_instr[rd_ptr[AW-1:0]];
  assign head_pc    = q_pc[rd_ptr[AW-1:0]];
  assign rs1_idx    = head_instr[19:15];
  assign rs2_idx    = head_instr[24:20];
  assign f3         = head_instr[14:12];
  // Low opcode bits other than 2'b11 map onto an unused major opcode so they fall into the illegal default.
  assign opc        = (head_instr[1:0] == 2'b11) ? head_instr[6:2] : 5'b11111;
  assign bus.rf_rs1_index = rs1_idx;
  assign bus.rf_rs2_index = rs2_idx;

  assign byp1 = bus.wb_valid && (bus.wb_rd == rs1_idx) && (rs1_idx != '0) && (sb_cnt[rs1_idx] == CNT_ONE);
  assign byp2 = bus.wb_valid && (bus.wb_rd == rs2_idx) && (rs2_idx != '0) && (sb_cnt[rs2_idx] == CNT_ONE);
  assign rdy1 = (rs1_idx == '0) || (sb_cnt[rs1_idx] == '0) || byp1;
  assign rdy2 = (rs2_idx == '0) || (sb_cnt[rs2_idx] == '0) || byp2;
  assign rs1_val = (rs1_idx == '0) ? '0 : byp1 ? bus.wb_data : bus.rf_rs1;
  assign rs2_val = (rs2_idx == '0) ? '0 : byp2 ? bus.wb_data : bus.rf_rs2;
  assign rs1_rev = {<<{rs1_val}};

  // Decode of the queue head
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, dec_a, dec_b;
  logic [4:0]  dec_rd;
  ctrl_t       ctrl;

  assign imm_i = {{20{head_instr[31]}}, head_instr[31:20]};
  assign imm_s = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
  assign imm_b = {{19{head_instr[31]}}, head_instr[31], head_instr[7], head_instr[30:25], head_instr[11:8], 1'b0};
  assign imm_u = {head_instr[31:12], 12'b0};
  assign imm_j = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12], head_instr[20], head_instr[30:21], 1'b0};

  // NOTE: every output of a combinational block is given a default first so no latch is inferred.
  always_comb begin
    ctrl   = '0;
    dec_a  = rs1_val;
    dec_b  = imm_i;
    dec_rd = head_instr[11:7];
    need1  = 1'b0;
    need2  = 1'b0;
    case (opc)
      OPC_OP, OPC_OPIMM: begin
        need1 = 1'b1;
        need2 = (opc == OPC_OP);
        if (opc == OPC_OP) dec_b = rs2_val;
        if (f3[1:0] == 2'b01) begin
          // Left shifts run through the right shifter on bit-reversed data.
          ctrl.wb_sel     = 2'd3;
          ctrl.alu_op     = {f3[2], head_instr[30]};
          ctrl.reverse_wb = !f3[2];
          if (!f3[2]) dec_a = rs1_rev;
          if (opc == OPC_OPIMM) dec_b[10] = 1'b0;
        end else if (f3[2]) begin
          ctrl.alu_sel_logic = 1'b1;
          ctrl.alu_op        = f3[1:0];
          ctrl.wb_sel        = 2'd2;
        end else begin
          ctrl.wb_sel = 2'd2;
          if (f3[1]) begin
            ctrl.alu_op       = 2'b01;
            ctrl.lt           = 1'b1;
            ctrl.unsigned_cmp = f3[0];
          end else begin
            ctrl.alu_op = {1'b0, (opc == OPC_OP) && head_instr[30]};
          end
        end
      end
      OPC_LOAD: begin
        need1             = 1'b1;
        ctrl.mem          = 1'b1;
        ctrl.mem_width    = f3[1:0];
        ctrl.mem_unsigned = f3[2];
      end
      OPC_STORE: begin
        need1          = 1'b1;
        need2          = 1'b1;
        ctrl.mem       = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.mem_width = f3[1:0];
        dec_b          = imm_s;
        dec_rd         = '0;
      end
      OPC_BRANCH: begin
        need1             = 1'b1;
        need2             = 1'b1;
        ctrl.branch       = 1'b1;
        ctrl.alu_op       = 2'b01;
        ctrl.lt           = f3[2];
        ctrl.invert_cmp   = f3[0];
        ctrl.unsigned_cmp = f3[1];
        dec_a             = head_pc;
        dec_b             = imm_b;
        dec_rd            = '0;
      end
      OPC_JAL: begin
        ctrl.branch       = 1'b1;
        ctrl.wb_sel       = 2'd1;
        ctrl.unsigned_cmp = 1'b1;
        dec_a             = head_pc;
        dec_b             = imm_j;
      end
      OPC_JALR: begin
        need1             = 1'b1;
        ctrl.branch       = 1'b1;
        ctrl.wb_sel       = 2'd1;
        ctrl.unsigned_cmp = 1'b1;
      end
      OPC_LUI: begin
        ctrl.wb_sel = 2'd2;
        dec_a       = '0;
        dec_b       = imm_u;
      end
      OPC_AUIPC: begin
        ctrl.wb_sel = 2'd2;
        dec_a       = head_pc;
        dec_b       = imm_u;
      end
      default: begin
        ctrl.illegal = 1'b1;
        dec_a        = '0;
        dec_b        = '0;
        dec_rd       = '0;
      end
    endcase
  end

  assign hazard = (need1 && !rdy1) || (need2 && !rdy2) ||
                  ((dec_rd != '0) && (sb_cnt[dec_rd] == CNT_MAX));
  assign issue  = !empty && (!bus.de_valid || bus.de_ready) && !hazard && !bus.flush;

  // Scoreboard: one increment source (issue) and two decrement sources (writeback, flushed slot).
  function automatic logic [CNT_W-1:0] sb_upd(logic [CNT_W-1:0] c, logic inc, logic dec_wb, logic dec_fl);
    int v;
    v = int'(c) + int'(inc) - int'(dec_wb) - int'(dec_fl);
    return (v < 0) ? '0 : CNT_W'(v);
  endfunction

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      sb_next[i] = sb_upd(sb_cnt[i],
                          issue && (dec_rd == 5'(i)) && (i != 0),
                          bus.wb_valid && (bus.wb_rd == 5'(i)) && (i != 0),
                          bus.flush && bus.de_valid && (bus.de_rd == 5'(i)) && (i != 0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) sb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) sb_cnt[i] <= sb_next[i];
    end
  end

  // Output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.de_valid   <= 1'b0;
      bus.de_pc      <= '0;
      bus.de_alu_a   <= '0;
      bus.de_alu_b   <= '0;
      bus.de_alu_rs1 <= '0;
      bus.de_alu_rs2 <= '0;
      bus.de_rd      <= '0;
      bus.de_ctrl    <= '0;
    end else if (bus.flush) begin
      bus.de_valid <= 1'b0;
    end else if (issue) begin
      bus.de_valid   <= 1'b1;
      bus.de_pc      <= head_pc;
      bus.de_alu_a   <= dec_a;
      bus.de_alu_b   <= dec_b;
      bus.de_alu_rs1 <= rs1_val;
      bus.de_alu_rs2 <= rs2_val;
      bus.de_rd      <= dec_rd;
      bus.de_ctrl    <= ctrl;
    end else if (bus.de_ready) begin
      bus.de_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_furv_de_queued.sv
// Directed bench for the queued decode stage (DEPTH=2, CNT_W=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_furv_de_queued;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] rf [32];

  furv_de_queued_if bus ();

  furv_de_queued #(.DEPTH(2), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.rf_rs1 = rf[bus.rf_rs1_index];
    bus.rf_rs2 = rf[bus.rf_rs2_index];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] word, input logic [31:0] pc);
    bus.fe_valid       = 1'b1;
    bus.fe_instruction = word;
    bus.fe_pc          = pc;
    step();
    bus.fe_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    bus.wb_data  = data;
    step();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = '0;
    bus.fe_valid       = 1'b0;
    bus.fe_instruction = '0;
    bus.fe_pc          = '0;
    bus.wb_valid       = 1'b0;
    bus.wb_rd          = '0;
    bus.wb_data        = '0;
    bus.flush          = 1'b0;
    bus.de_ready       = 1'b1;

    // Reset state
    #3;
    check("rst_de_valid", 32'(bus.de_valid), 32'd0);
    check("rst_fe_ready", 32'(bus.fe_ready), 32'd1);
    check("rst_de_ctrl", 32'(bus.de_ctrl), 32'd0);
    check("rst_de_pc", bus.de_pc, 32'd0);
    step();
    rst = 1'b0;
    step();

    // 1: ADDI x1,x0,5 issues one edge after the push
    push(32'h00500093, 32'h100);
    check("t1_not_yet", 32'(bus.de_valid), 32'd0);
    step();
    check("t1_de_valid", 32'(bus.de_valid), 32'd1);
    check("t1_de_rd", 32'(bus.de_rd), 32'd1);
    check("t1_alu_a", bus.de_alu_a, 32'd0);
    check("t1_alu_b", bus.de_alu_b, 32'd5);
    check("t1_pc", bus.de_pc, 32'h100);
    check("t1_ctrl", 32'(bus.de_ctrl), 32'h1000);
    check("t1_cnt1", 32'(dut.sb_cnt[1]), 32'd1);
    wb(5'd1, 32'd5);
    check("t1_cnt1_clr", 32'(dut.sb_cnt[1]), 32'd0);

    // Decode: SLL x15,x16,x17 then BLTU x16,x17,+8
    push(32'h011817B3, 32'h400);
    push(32'h01186463, 32'h404);
    check("sll_alu_a_rev", bus.de_alu_a, 32'h08800000);
    check("sll_alu_b", bus.de_alu_b, 32'h111);
    check("sll_ctrl", 32'(bus.de_ctrl), 32'h1810);
    check("sll_rd", 32'(bus.de_rd), 32'd15);
    step();
    check("bltu_ctrl", 32'(bus.de_ctrl), 32'h240A);
    check("bltu_rd", 32'(bus.de_rd), 32'd0);
    check("bltu_alu_a", bus.de_alu_a, 32'h404);
    check("bltu_alu_b", bus.de_alu_b, 32'd8);
    check("bltu_rs1", bus.de_alu_rs1, 32'h110);
    check("bltu_rs2", bus.de_alu_rs2, 32'h111);
    wb(5'd15, 32'h0);
    check("sll_cnt15_clr", 32'(dut.sb_cnt[15]), 32'd0);

    // 2: RAW hazard on x1, queue fills, writeback bypass releases ADD
    push(32'h00500093, 32'h500);
    push(32'h00108133, 32'h504);
    check("t2_addi_rd", 32'(bus.de_rd), 32'd1);
    bus.fe_valid       = 1'b1;
    bus.fe_instruction = 32'h00100293;
    bus.fe_pc          = 32'h508;
    step();
    check("t2_full", 32'(bus.fe_ready), 32'd0);
    check("t2_add_held", 32'(bus.de_valid), 32'd0);
    bus.fe_instruction = 32'h00100313;
    bus.fe_pc          = 32'h50C;
    step();
    check("t2_still_full", 32'(bus.fe_ready), 32'd0);
    check("t2_add_held2", 32'(bus.de_valid), 32'd0);
    bus.fe_valid = 1'b0;
    wb(5'd1, 32'd7);
    check("t2_add_valid", 32'(bus.de_valid), 32'd1);
    check("t2_add_a", bus.de_alu_a, 32'd7);
    check("t2_add_b", bus.de_alu_b, 32'd7);
    check("t2_add_rd", 32'(bus.de_rd), 32'd2);
    check("t2_add_pc", bus.de_pc, 32'h504);
    check("t2_cnt1", 32'(dut.sb_cnt[1]), 32'd0);
    check("t2_cnt2", 32'(dut.sb_cnt[2]), 32'd1);
    check("t2_ready_again", 32'(bus.fe_ready), 32'd1);
    step();
    check("t2_filler_rd", 32'(bus.de_rd), 32'd5);
    check("t2_filler_pc", bus.de_pc, 32'h508);
    wb(5'd2, 32'h0);
    wb(5'd5, 32'h0);
    check("t2_no_extra", 32'(bus.de_valid), 32'd0);

    // 3: WAW counter saturation on x3
    for (int k = 0; k < 4; k++) push(32'h00100193, 32'h600 + 32'(4 * k));
    step();
    check("t3_cnt_max", 32'(dut.sb_cnt[3]), 32'd3);
    check("t3_stall", 32'(bus.de_valid), 32'd0);
    step();
    check("t3_stall2", 32'(bus.de_valid), 32'd0);
    wb(5'd3, 32'h0);
    check("t3_cnt_dec", 32'(dut.sb_cnt[3]), 32'd2);
    step();
    check("t3_issue", 32'(bus.de_valid), 32'd1);
    check("t3_issue_pc", bus.de_pc, 32'h60C);
    check("t3_cnt_back", 32'(dut.sb_cnt[3]), 32'd3);
    for (int k = 0; k < 3; k++) wb(5'd3, 32'h0);
    check("t3_cnt_clr", 32'(dut.sb_cnt[3]), 32'd0);

    // 4: output hold while execute is stalled
    bus.de_ready = 1'b0;
    push(32'h00900393, 32'h200);
    push(32'h00A00413, 32'h204);
    push(32'h00B00493, 32'h208);
    check("t4_slot_pc", bus.de_pc, 32'h200);
    check("t4_full", 32'(bus.fe_ready), 32'd0);
    bus.fe_valid       = 1'b1;
    bus.fe_instruction = 32'h00C00513;
    bus.fe_pc          = 32'h20C;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_hold_pc", bus.de_pc, 32'h200);
      check("t4_hold_b", bus.de_alu_b, 32'd9);
      check("t4_hold_rd", 32'(bus.de_rd), 32'd7);
      check("t4_hold_full", 32'(bus.fe_ready), 32'd0);
    end
    bus.de_ready = 1'b1;
    step();
    check("t4_p2_pc", bus.de_pc, 32'h204);
    check("t4_p2_ready", 32'(bus.fe_ready), 32'd1);
    step();
    check("t4_p3_pc", bus.de_pc, 32'h208);
    bus.fe_valid = 1'b0;
    step();
    check("t4_p4_pc", bus.de_pc, 32'h20C);
    check("t4_p4_rd", 32'(bus.de_rd), 32'd10);
    step();
    check("t4_drained", 32'(bus.de_valid), 32'd0);
    for (int r = 7; r <= 10; r++) wb(5'(r), 32'h0);

    // 5: illegal words, then flush with ADDI x4 in the slot
    push(32'h00000000, 32'h300);
    push(32'h00000F8F, 32'h304);
    check("t5_ill_ctrl", 32'(bus.de_ctrl), 32'h0001);
    check("t5_ill_rd", 32'(bus.de_rd), 32'd0);
    check("t5_ill_pc", bus.de_pc, 32'h300);
    push(32'h00300213, 32'h308);
    check("t5_fence_ctrl", 32'(bus.de_ctrl), 32'h0001);
    check("t5_fence_rd", 32'(bus.de_rd), 32'd0);
    check("t5_fence_cnt31", 32'(dut.sb_cnt[31]), 32'd0);
    step();
    check("t5_addi_rd", 32'(bus.de_rd), 32'd4);
    check("t5_cnt4", 32'(dut.sb_cnt[4]), 32'd1);
    bus.de_ready = 1'b0;
    push(32'h00100293, 32'h30C);
    bus.flush          = 1'b1;
    bus.fe_valid       = 1'b1;
    bus.fe_instruction = 32'h00100313;
    bus.fe_pc          = 32'h310;
    step();
    bus.flush    = 1'b0;
    bus.fe_valid = 1'b0;
    check("t5_flush_valid", 32'(bus.de_valid), 32'd0);
    check("t5_flush_cnt4", 32'(dut.sb_cnt[4]), 32'd0);
    check("t5_flush_ready", 32'(bus.fe_ready), 32'd1);
    bus.de_ready = 1'b1;
    step();
    check("t5_queue_empty", 32'(bus.de_valid), 32'd0);
    check("t5_cnt5", 32'(dut.sb_cnt[5]), 32'd0);

    // 6: asynchronous reset in the middle of a stall
    bus.de_ready = 1'b0;
    push(32'h00100593, 32'h700);
    push(32'h00100613, 32'h704);
    push(32'h00100693, 32'h708);
    check("t6_cnt11", 32'(dut.sb_cnt[11]), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("t6_valid", 32'(bus.de_valid), 32'd0);
    check("t6_pc", bus.de_pc, 32'd0);
    check("t6_alu_a", bus.de_alu_a, 32'd0);
    check("t6_alu_b", bus.de_alu_b, 32'd0);
    check("t6_rd", 32'(bus.de_rd), 32'd0);
    check("t6_ctrl", 32'(bus.de_ctrl), 32'd0);
    check("t6_cnt11", 32'(dut.sb_cnt[11]), 32'd0);
    check("t6_fe_ready", 32'(bus.fe_ready), 32'd1);
    #1 rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
